// File: rtl/mac_result_accum.sv
// Accumulates a programmable number of ffra result terms into one saturating sum.
// Finished sums go into a small result FIFO. Input samples lost while stalled are counted.
module mac_result_accum #(
  parameter int DATA_W     = 16,
  parameter int ACC_W      = 20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          in_ready,
  input  logic [7:0]                    cfg_len,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ACC_W-1:0]              out_data,
  output logic                          out_sat,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    drop_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

  state_t             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic               r_sat;
  logic [8:0]         r_remaining;
  logic [ACC_W-1:0]   r_mem_data [FIFO_DEPTH];
  logic               r_mem_sat  [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [LVL_W-1:0]   r_level;
  logic [7:0]         r_drop_cnt;

  logic               w_first;
  logic               w_accept;
  logic [8:0]         w_len;
  logic [ACC_W-1:0]   w_base;
  logic [ACC_W:0]     w_sum;
  logic               w_ovf;
  logic [ACC_W-1:0]   w_acc_new;
  logic               w_sat_new;
  logic               w_last;
  logic               w_complete;
  logic               w_pop;
  logic               w_space;
  logic               w_push;
  logic [ACC_W-1:0]   w_push_data;
  logic               w_push_sat;
  logic               w_drop;

  assign in_ready   = (r_state != S_HOLD);
  assign busy       = (r_state != S_IDLE);
  assign out_valid  = (r_level != '0);
  assign out_data   = out_valid ? r_mem_data[r_rd_ptr] : '0;
  assign out_sat    = out_valid ? r_mem_sat[r_rd_ptr] : 1'b0;
  assign fifo_level = r_level;
  assign drop_cnt   = r_drop_cnt;

  // The first term of a group starts from zero, so it can never overflow.
  assign w_first    = (r_state == S_IDLE);
  assign w_accept   = in_valid && in_ready;
  assign w_len      = (cfg_len == 8'd0) ? 9'd256 : {1'b0, cfg_len};
  assign w_base     = w_first ? '0 : r_acc;
  assign w_sum      = {1'b0, w_base} + {{(ACC_W + 1 - DATA_W){1'b0}}, in_data};
  assign w_ovf      = w_sum[ACC_W];
  assign w_acc_new  = w_ovf ? '1 : w_sum[ACC_W-1:0];
  assign w_sat_new  = (!w_first && r_sat) || w_ovf;
  assign w_last     = w_first ? (w_len == 9'd1) : (r_remaining == 9'd1);
  assign w_complete = w_accept && w_last;

  assign w_pop       = out_valid && out_ready;
  assign w_space     = (r_level != LVL_W'(FIFO_DEPTH)) || w_pop;
  assign w_push      = w_space && ((r_state == S_HOLD) || w_complete);
  assign w_push_data = (r_state == S_HOLD) ? r_acc : w_acc_new;
  assign w_push_sat  = (r_state == S_HOLD) ? r_sat : w_sat_new;
  assign w_drop      = in_valid && !in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_sat       <= 1'b0;
      r_remaining <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_acc       <= w_acc_new;
            r_sat       <= w_sat_new;
            r_remaining <= w_len - 9'd1;
            if (w_last) r_state <= w_space ? S_IDLE : S_HOLD;
            else        r_state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            r_acc       <= w_acc_new;
            r_sat       <= w_sat_new;
            r_remaining <= r_remaining - 9'd1;
            if (w_last) r_state <= w_space ? S_IDLE : S_HOLD;
          end
        end
        S_HOLD: begin
          if (w_space) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Storage needs no reset: reads are masked to zero whenever the FIFO is empty.
  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (w_push && (r_wr_ptr == PTR_W'(gi))) begin
          r_mem_data[gi] <= w_push_data;
          r_mem_sat[gi]  <= w_push_sat;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_level <= r_level + LVL_W'(w_push) - LVL_W'(w_pop);
      if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_mac_result_accum.sv
// Bench for mac_result_accum: directed scenarios plus randomized traffic,
// checked every cycle against a group/queue level reference model.
module tb_mac_result_accum;

  localparam int DATA_W     = 16;
  localparam int ACC_W      = 20;
  localparam int FIFO_DEPTH = 4;
  localparam longint ACC_MAX = (64'd1 << ACC_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic [7:0]        cfg_len = 8'd0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ACC_W-1:0]  out_data;
  logic              out_sat;
  logic              busy;
  logic [2:0]        fifo_level;
  logic [7:0]        drop_cnt;

  mac_result_accum #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .cfg_len(cfg_len),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
    .busy(busy), .fifo_level(fifo_level), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: FIFO as a queue of {sat, value}, group as a plain integer sum.
  logic [ACC_W:0]   m_fifo[$];
  bit               m_held = 0;
  logic [ACC_W:0]   m_held_val = '0;
  bit               m_in_group = 0;
  int               m_left = 0;
  longint           m_sum = 0;
  int               m_drop = 0;
  logic [ACC_W-1:0] got[$];

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_held = 0;
    m_in_group = 0;
    m_left = 0;
    m_sum = 0;
    m_drop = 0;
  endtask

  task automatic model_step();
    bit pop, space, complete;
    logic [ACC_W:0] res;
    pop = (m_fifo.size() > 0) && out_ready;
    space = (m_fifo.size() < FIFO_DEPTH) || pop;
    complete = 0;
    res = '0;
    if (in_valid && m_held && m_drop < 255) m_drop++;
    if (in_valid && !m_held) begin
      if (!m_in_group) begin
        m_in_group = 1;
        m_sum = 0;
        m_left = (cfg_len == 8'd0) ? 256 : int'(cfg_len);
      end
      m_sum += longint'(in_data);
      m_left--;
      if (m_left == 0) begin
        complete = 1;
        m_in_group = 0;
        res[ACC_W] = (m_sum > ACC_MAX);
        res[ACC_W-1:0] = ACC_W'((m_sum > ACC_MAX) ? ACC_MAX : m_sum);
      end
    end
    if (pop) void'(m_fifo.pop_front());
    if (m_held) begin
      if (space) begin
        m_fifo.push_back(m_held_val);
        m_held = 0;
      end
    end else if (complete) begin
      if (space) m_fifo.push_back(res);
      else begin
        m_held = 1;
        m_held_val = res;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset();
    else model_step();
  end

  // Per-cycle comparison away from the active edge.
  initial forever begin
    logic [ACC_W:0] head;
    @(negedge clk);
    head = (m_fifo.size() > 0) ? m_fifo[0] : '0;
    chk("in_ready", in_ready, !m_held);
    chk("out_valid", out_valid, m_fifo.size() > 0);
    chk("out_data", out_data, head[ACC_W-1:0]);
    chk("out_sat", out_sat, head[ACC_W]);
    chk("busy", busy, m_in_group || m_held);
    chk("fifo_level", fifo_level, m_fifo.size());
    chk("drop_cnt", drop_cnt, m_drop);
    if (out_valid && out_ready) got.push_back(out_data);
  end

  task automatic tick(input logic v, input logic [DATA_W-1:0] d);
    in_valid = v;
    in_data = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_busy", busy, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_drop", drop_cnt, 0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Four-term group, result visible one cycle after the last term.
    cfg_len = 8'd4;
    out_ready = 1'b1;
    tick(1, 100); tick(1, 200); tick(1, 300);
    chk("t1_not_yet", out_valid, 0);
    tick(1, 400);
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 1000);
    chk("t1_sat", out_sat, 0);
    tick(0, 0);
    chk("t1_popped", out_valid, 0);

    // Full-scale terms: just below and just past saturation.
    cfg_len = 8'd16;
    repeat (16) tick(1, 16'hFFFF);
    chk("t2_data16", out_data, 1048560);
    chk("t2_sat16", out_sat, 0);
    cfg_len = 8'd17;
    repeat (17) tick(1, 16'hFFFF);
    chk("t2_data17", out_data, 1048575);
    chk("t2_sat17", out_sat, 1);
    tick(0, 0);

    // Backpressure: fill FIFO, hold one result, drop one sample.
    out_ready = 1'b0;
    cfg_len = 8'd1;
    for (int i = 1; i <= 6; i++) tick(1, DATA_W'(i));
    chk("t3_level", fifo_level, 4);
    chk("t3_in_ready", in_ready, 0);
    chk("t3_drop", drop_cnt, 1);
    in_valid = 1'b0;
    got.delete();
    out_ready = 1'b1;
    repeat (8) tick(0, 0);
    chk("t3_count", got.size(), 5);
    for (int k = 0; k < 5 && k < got.size(); k++) chk("t3_order", got[k], k + 1);
    chk("t3_in_ready_back", in_ready, 1);

    // Length 0 means 256; mid-group cfg change affects only the next group.
    cfg_len = 8'd0;
    for (int i = 0; i < 256; i++) begin
      if (i == 10) cfg_len = 8'd3;
      tick(1, 1);
    end
    chk("t4_valid", out_valid, 1);
    chk("t4_data", out_data, 256);
    repeat (3) tick(1, 5);
    chk("t4_next_data", out_data, 15);
    tick(0, 0);

    // Asynchronous reset mid-group with a stored result and nonzero drop count.
    out_ready = 1'b0;
    cfg_len = 8'd1;
    tick(1, 9);
    cfg_len = 8'd8;
    repeat (5) tick(1, 2);
    in_valid = 1'b0;
    chk("t5_busy_pre", busy, 1);
    chk("t5_level_pre", fifo_level, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_valid", out_valid, 0);
    chk("t5_level", fifo_level, 0);
    chk("t5_busy", busy, 0);
    chk("t5_drop", drop_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (8) tick(1, 2);
    chk("t5_data", out_data, 16);
    tick(0, 0);

    // Completion into a full FIFO while it pops.
    out_ready = 1'b0;
    cfg_len = 8'd1;
    for (int i = 11; i <= 14; i++) tick(1, DATA_W'(i));
    cfg_len = 8'd2;
    tick(1, 7);
    chk("t6_level_full", fifo_level, 4);
    out_ready = 1'b1;
    tick(1, 8);
    chk("t6_level", fifo_level, 4);
    chk("t6_in_ready", in_ready, 1);
    chk("t6_head", out_data, 12);
    repeat (6) tick(0, 0);
    chk("t6_drained", fifo_level, 0);

    // Drop counter saturation.
    out_ready = 1'b0;
    cfg_len = 8'd1;
    repeat (300) tick(1, DATA_W'($urandom));
    chk("t7_drop_sat", drop_cnt, 255);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (8) tick(0, 0);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if (!busy || $urandom_range(0, 7) == 0)
        cfg_len = ($urandom_range(0, 19) == 0) ? 8'($urandom) : 8'($urandom_range(1, 6));
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 499) == 0) begin
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
      end
      tick($urandom_range(0, 3) != 0,
           ($urandom_range(0, 3) == 0) ? 16'hFFFF : DATA_W'($urandom));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (10) tick(0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mac_result_accum.md
Name: mac_result_accum

Overview:
Downstream stage of the ffra multiply-add core. It consumes the 16-bit ffra result stream (o) and accumulates a programmable number of consecutive terms into one dot-product result. Completed results are buffered in a small FIFO and drained by the consumer through a valid/ready handshake. The stage also counts input samples lost to backpressure, because ffra itself has no stall capability.

Parameters:
DATA_W, 16, width of each input term (ffra o width), unsigned
ACC_W, 20, accumulator and result width; must be greater than DATA_W
FIFO_DEPTH, 4, number of result FIFO entries; power of two, at least 2

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  in_data holds a new ffra result this cycle
in_data  input  DATA_W  ffra result term
in_ready  output  1  stage accepts in_data this cycle
cfg_len  input  8  terms per group; 0 means 256; latched on the first term of each group
out_valid  output  1  FIFO head is valid
out_ready  input  1  consumer takes the FIFO head
out_data  output  ACC_W  accumulated group result (FIFO head)
out_sat  output  1  head result saturated
busy  output  1  group in progress (state ACCUM or HOLD)
fifo_level  output  clog2(FIFO_DEPTH)+1  FIFO occupancy
drop_cnt  output  8  count of samples dropped while in_ready=0; saturates at 255

Behaviour:
- Reset (async assert, sync release): state IDLE, acc=0, remaining=0, sat flag=0, FIFO empty, drop_cnt=0.
  - Output reset values: in_ready=1, out_valid=0, out_data=0, out_sat=0, busy=0, fifo_level=0.
- A term is accepted when in_valid && in_ready.
- Arithmetic:
  - acc_next = acc + zero-extended in_data.
  - If the sum exceeds 2^ACC_W-1, acc clamps to 2^ACC_W-1 and the group sat flag is set. The sat flag stays set for the rest of the group.
- State IDLE:
  - in_ready=1.
  - On accept: acc=in_data, sat=0, len_q=cfg_len (0 maps to 256), remaining=len_q-1.
  - If len_q==1, the group completes this cycle.
  - Otherwise go to ACCUM.
- State ACCUM:
  - in_ready=1.
  - Each accept adds the term to acc and decrements remaining.
  - The term accepted while remaining==1 completes the group.
  - cfg_len changes are ignored until the next group.
- Completion:
  - The final value {sat, acc} (including the last term) is pushed to the FIFO in the completion cycle if space is available, then the state goes to IDLE.
  - Space is available when fifo_level<FIFO_DEPTH, or when a pop occurs in the same cycle.
  - If no space, latch the result and go to HOLD.
- State HOLD:
  - in_ready=0.
  - Push the held result the first cycle space is available, then go to IDLE.
  - in_ready returns to 1 the cycle after the push.
- Drop counting: any cycle with in_valid && !in_ready increments drop_cnt, saturating at 255. Only reset clears drop_cnt.
- Latency:
  - Last term accepted in cycle t with FIFO empty: out_valid=1 and out_data valid in cycle t+1.
  - Throughput is one term per cycle with no bubbles between groups.
- FIFO:
  - out_valid = level!=0.
  - out_data/out_sat come from the head and are zero when empty.
  - Pop on out_valid && out_ready.
  - Simultaneous push and pop leaves the level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - out_data is held stable while out_valid && !out_ready.
- Reset mid-group: the partial accumulation and all FIFO contents are discarded with no output.

Test Plan:
- cfg_len=4; terms 100, 200, 300, 400 back-to-back; out_ready=1 -> one result out_data=1000, out_sat=0, out_valid high exactly one cycle after the 400 is accepted.
- cfg_len=16, all terms 0xFFFF -> out_data=1048560, sat=0. Then cfg_len=17, all terms 0xFFFF -> out_data=1048575 (0xFFFFF), out_sat=1.
- cfg_len=1, out_ready=0, 6 consecutive valid terms (1..6):
  - FIFO fills with 1, 2, 3, 4.
  - Term 5 enters HOLD and in_ready=0; term 6 is dropped, drop_cnt=1.
  - Then out_ready=1 -> pops 1, 2, 3, 4, 5 in order; term 6 never appears.
- cfg_len=0 (256 terms of value 1), with cfg_len changed to 3 after term 10 -> single result 256. The next group then uses length 3.
- cfg_len=8; assert rst_n low asynchronously after 5 terms -> out_valid, fifo_level, busy and drop_cnt go to 0 immediately. After release, 8 terms of 2 -> out_data=16.
- FIFO full with out_ready=1 and a group completing in the same cycle -> push and pop coincide, fifo_level stays 4, in_ready never drops.
